picomips_prog_loader: RTL and testbench

//  Byte-stream program loader that writes instruction words into picoMIPS instruction memory.
//  It is the writer side of the instruction path. It assembles bytes into IW-bit words and

---
 rtl/picomips_prog_loader.sv | 121 ++++++++++++
 tb/tb_picomips_prog_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/picomips_prog_loader.sv
// picoMIPS program loader: assembles a byte stream into IW-bit instruction words,
// screens opcodes, writes imem and releases the CPU after a good checksum.
module picomips_prog_loader #(
  parameter int IW = 20,  // must exceed 8 so a word spans more than one byte
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          load_start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          cpu_run,
  output logic          load_busy,
  output logic          err
);
  localparam int BPW = (IW + 7) / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CAP = 2 ** AW;

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;

  state_t          state, state_next;
  logic [BCW-1:0]  byte_cnt;
  logic [AW-1:0]   word_idx;
  logic [7:0]      words_left;
  logic [7:0]      sum;
  logic [IW-9:0]   shreg;  // earlier bytes of the current word; pad bits fall off the top

  logic            accept;
  logic [IW-1:0]   word;
  logic [2:0]      opcode;
  logic            op_bad;
  logic            last_byte;
  logic            count_bad;
  logic [7:0]      sum_next;

  assign accept    = rx_valid & rx_ready;
  assign word      = {shreg, rx_data};
  assign opcode    = word[IW-1:IW-3];
  assign op_bad    = (opcode == 3'b011) || (opcode == 3'b101);
  assign last_byte = (byte_cnt == BCW'(BPW - 1));
  assign count_bad = (rx_data == 8'd0) || (int'(rx_data) > CAP);
  assign sum_next  = sum + rx_data;

  assign rx_ready  = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign load_busy = rx_ready;
  assign cpu_run   = (state == DONE);
  assign err       = (state == ERROR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (load_start) state_next = COUNT;
      COUNT: if (accept) state_next = count_bad ? ERROR : DATA;
      DATA: begin
        if (accept && last_byte) begin
          if (op_bad)                  state_next = ERROR;
          else if (words_left == 8'd1) state_next = CHECK;
        end
      end
      CHECK: if (accept) state_next = (sum_next == 8'd0) ? DONE : ERROR;
      DONE,
      ERROR: if (load_start) state_next = COUNT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_idx   <= '0;
      words_left <= '0;
      sum        <= '0;
      shreg      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_next;
      imem_we <= 1'b0;
      case (state)
        COUNT: if (accept) begin
          sum        <= rx_data;
          words_left <= rx_data;
          word_idx   <= '0;
          byte_cnt   <= '0;
          shreg      <= '0;
        end
        DATA: if (accept) begin
          sum <= sum_next;
          if (last_byte) begin
            byte_cnt <= '0;
            shreg    <= '0;
            if (!op_bad) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= word;
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 8'd1;
            end
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            shreg    <= word[IW-9:0];
          end
        end
        CHECK: if (accept) sum <= sum_next;
        default: if (load_start) begin
          sum      <= '0;
          byte_cnt <= '0;
          word_idx <= '0;
          shreg    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_picomips_prog_loader.sv
// Directed bench for picomips_prog_loader: a per-cycle vector table plus
// hand-written gapped-load and mid-load reset sequences.
module tb_picomips_prog_loader;
  logic        clk = 1'b0;
  logic        n_reset, load_start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_run, load_busy, err;
  logic [7:0]  imem_addr;
  logic [19:0] imem_wdata;

  int tests = 0;
  int fails = 0;

  picomips_prog_loader #(.IW(20), .AW(8)) dut (
    .clk(clk), .n_reset(n_reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_busy(load_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, ls, rv;
    logic [7:0]  rd;
    logic        we;
    logic [7:0]  addr;
    logic [19:0] wd;
    logic        rdy, run, er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic ls, logic rv, logic [7:0] rd,
                              logic we, logic [7:0] addr, logic [19:0] wd,
                              logic rdy, logic run, logic er);
    vec_t v;
    v.rst_n = rst_n; v.ls = ls; v.rv = rv; v.rd = rd;
    v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy; v.run = run; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample just after the following rising edge.
  task automatic step(input logic rst_n, input logic ls, input logic rv, input logic [7:0] rd);
    @(negedge clk);
    n_reset = rst_n; load_start = ls; rx_valid = rv; rx_data = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [7:0] addr,
                         input logic [19:0] wd, input logic rdy, input logic run, input logic er);
    chk({tag, " we"},    32'(imem_we),    32'(we));
    chk({tag, " addr"},  32'(imem_addr),  32'(addr));
    chk({tag, " wdata"}, 32'(imem_wdata), 32'(wd));
    chk({tag, " ready"}, 32'(rx_ready),   32'(rdy));
    chk({tag, " busy"},  32'(load_busy),  32'(rdy));
    chk({tag, " run"},   32'(cpu_run),    32'(run));
    chk({tag, " err"},   32'(err),        32'(er));
  endtask

  // Full two-word load; bytes packed MSB first in bs, gap idle cycles before each byte.
  task automatic load_check(input string tag, input logic [63:0] bs, input int gap,
                            input logic [19:0] w0, input logic [19:0] w1);
    int nwr;
    logic [7:0]  a[2];
    logic [19:0] d[2];
    nwr = 0;
    step(1, 1, 0, 8'h00);
    chk({tag, " start busy"}, 32'(load_busy), 32'd1);
    chk({tag, " start run"},  32'(cpu_run),   32'd0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        step(1, 0, 0, 8'h00);
        if (imem_we) nwr++;
      end
      step(1, 0, 1, bs[63-8*i -: 8]);
      if (imem_we) begin
        if (nwr < 2) begin a[nwr] = imem_addr; d[nwr] = imem_wdata; end
        nwr++;
      end
    end
    chk({tag, " writes"}, 32'(nwr), 32'd2);
    if (nwr == 2) begin
      chk({tag, " addr0"},  32'(a[0]), 32'h0);
      chk({tag, " data0"},  32'(d[0]), 32'(w0));
      chk({tag, " addr1"},  32'(a[1]), 32'h1);
      chk({tag, " data1"},  32'(d[1]), 32'(w1));
    end
    chk({tag, " run"},   32'(cpu_run), 32'd1);
    chk({tag, " err"},   32'(err),     32'd0);
    chk({tag, " ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    n_reset = 0; load_start = 0; rx_valid = 0; rx_data = 8'h00;

    // Clean load, with a gap and an ignored load_start inside DATA; checksum A5 closes the sum
    vecs.push_back(mk(1,1,0,8'h00, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h02, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h02, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,0,0,8'h00, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,1,0,8'h00, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h00, 0,8'h0,20'h00000, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h05, 1,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h0C, 0,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h12, 0,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h34, 1,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,0,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'hA5, 0,8'h1,20'hC1234, 0,1,0));
    vecs.push_back(mk(1,0,1,8'h11, 0,8'h1,20'hC1234, 0,1,0));
    // Bad checksum: both words written, then ERROR
    vecs.push_back(mk(1,1,0,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h02, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h02, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h05, 1,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h0C, 0,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h12, 0,8'h0,20'h20005, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h34, 1,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'hA7, 0,8'h1,20'hC1234, 0,0,1));
    // Illegal opcode 011: no write, ERROR right after the third data byte, checksum refused
    vecs.push_back(mk(1,1,0,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h01, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h06, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h00, 0,8'h1,20'hC1234, 0,0,1));
    vecs.push_back(mk(1,0,1,8'hA5, 0,8'h1,20'hC1234, 0,0,1));
    // Zero count
    vecs.push_back(mk(1,1,0,8'h00, 0,8'h1,20'hC1234, 1,0,0));
    vecs.push_back(mk(1,0,1,8'h00, 0,8'h1,20'hC1234, 0,0,1));

    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk_all("reset", 0, 8'h0, 20'h0, 0, 0, 0);
    step(1, 0, 0, 8'h00);
    chk_all("idle", 0, 8'h0, 20'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].ls, vecs[i].rv, vecs[i].rd);
      chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd,
              vecs[i].rdy, vecs[i].run, vecs[i].er);
    end

    // Gapped load; pad nibble F in the first word's top byte must be dropped (checksum B5)
    load_check("gap", 64'h02_F2_00_05_0C_12_34_B5, 5, 20'h20005, 20'hC1234);
    step(1, 1, 0, 8'h00);
    chk("restart run",  32'(cpu_run),   32'd0);
    chk("restart busy", 32'(load_busy), 32'd1);

    // Reset mid-DATA after the first word has landed
    step(1, 0, 1, 8'h02);
    step(1, 0, 1, 8'h02);
    step(1, 0, 1, 8'h00);
    step(1, 0, 1, 8'h05);
    chk("mid we", 32'(imem_we), 32'd1);
    step(1, 0, 1, 8'h0C);
    step(0, 0, 1, 8'h12);
    chk_all("midreset", 0, 8'h0, 20'h0, 0, 0, 0);
    step(1, 0, 0, 8'h00);
    load_check("reload", 64'h02_02_00_05_0C_12_34_A5, 0, 20'h20005, 20'hC1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
